cluster_periph_demux: RTL and testbench
=======================================

Name: cluster_periph_demux

Overview:
- Routes requests from the cluster peripheral-interconnect master port to NB_SPERIPHS slave peripheral ports (EOC, timer, event unit, lockstep, HWPE, icache ctrl, DMA CL/FC, decompressor, ext).
- Tracks outstanding transactions so that responses return in order.
- Generates an internal error response for unmapped slave indices.
- Sits directly upstream of the peripheral slave plugs and consumes the SPER_* index map from pulp_cluster_package.

Parameters:
- NB_SPERIPHS, 11, number of slave ports; valid indices are 0..NB_SPERIPHS-1.
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- ID_WIDTH, 5, master transaction ID width.
- SEL_LSB, 10, LSB of the 4-bit slave-select field in the address (1 KiB per peripheral).
- MAX_OUTSTANDING, 4, maximum in-flight transactions; counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  1  master request
- m_add_i  in  ADDR_WIDTH  address
- m_wen_i  in  1  0 = write, 1 = read
- m_wdata_i  in  DATA_WIDTH  write data
- m_be_i  in  DATA_WIDTH/8  byte enables
- m_id_i  in  ID_WIDTH  transaction ID
- m_gnt_o  out  1  grant
- m_r_valid_o  out  1  response valid
- m_r_opc_o  out  1  response error flag
- m_r_id_o  out  ID_WIDTH  response ID
- m_r_rdata_o  out  DATA_WIDTH  read data
- s_req_o  out  NB_SPERIPHS  per-slave request
- s_add_o / s_wen_o / s_wdata_o / s_be_o / s_id_o  out  arrays [NB_SPERIPHS]  broadcast request fields
- s_gnt_i  in  NB_SPERIPHS  per-slave grant
- s_r_valid_i  in  NB_SPERIPHS  per-slave response valid
- s_r_opc_i  in  NB_SPERIPHS  per-slave error flag
- s_r_id_i  in  [NB_SPERIPHS] ID_WIDTH  per-slave response ID
- s_r_rdata_i  in  [NB_SPERIPHS] DATA_WIDTH  per-slave read data

Behaviour:
- Decode
  - sel = m_add_i[SEL_LSB+:4].
  - Mapped iff sel < NB_SPERIPHS; otherwise the target is the virtual error slave ERR = NB_SPERIPHS.
- State
  - out_cnt: outstanding count.
  - cur_tgt: target of all in-flight transactions.
  - err_pend, err_id: pending internal error response.
  - All reset to 0.
- Outputs at reset
  - m_gnt_o = 0, m_r_valid_o = 0, m_r_opc_o = 0, m_r_id_o = 0, m_r_rdata_o = 0, s_req_o = 0.
- Issue rule: the request may proceed iff all of the following hold:
  - out_cnt < MAX_OUTSTANDING;
  - out_cnt == 0 or tgt == cur_tgt (a different target waits until the count drains to 0, which preserves ordering);
  - for ERR only, err_pend == 0.
- Mapped target
  - s_req_o[sel] = m_req_i & proceed (combinational).
  - m_gnt_o = s_gnt_i[sel] & proceed.
  - Request fields are broadcast unmodified.
- ERR target
  - No slave request is driven; m_gnt_o = 1 when proceed.
  - The next cycle drives m_r_valid_o = 1, m_r_opc_o = 1, m_r_id_o = captured ID, m_r_rdata_o = 32'hBADACCE5 (replicated/truncated to DATA_WIDTH).
- On handshake (m_req_i & m_gnt_o): cur_tgt <= tgt, out_cnt++.
- Response path
  - Combinational mux from cur_tgt: m_r_* = s_r_*[cur_tgt] when out_cnt > 0.
  - Every m_r_valid_o decrements out_cnt.
  - Responses from non-current slaves, or arriving while out_cnt == 0, are dropped.
- Simultaneous handshake and response in the same cycle: out_cnt is unchanged.
- At out_cnt == MAX_OUTSTANDING: m_gnt_o = 0 until a response arrives. A grant in the same cycle as a response at full count is not allowed (no bypass).
- Latency
  - Zero-cycle request path.
  - Response latency equals slave latency; ERR latency is 1 cycle.
- Reset mid-operation: all state clears immediately (async); late slave responses are dropped because out_cnt == 0.

Optional Feature:
- Macro: CLUSTER_PERIPH_DEMUX_ERR_RESP_EN.
- Defined: behaviour as above; unmapped accesses get the internal error response.
- Undefined
  - Unmapped sel is redirected to SPER_EXT_ID: tgt = SPER_EXT_ID, and the address is forwarded unchanged.
  - No ERR logic or err_pend registers are instantiated.

Decomposition:
- Package pulp_cluster_package holds:
  - SPER_* indices and NB_SPERIPHS;
  - new constant PER_ERR_RDATA = 32'hBADACCE5;
  - new localparam PER_SEL_WIDTH = 4.
- Sub-module cluster_periph_demux_err_slv: the 1-cycle error responder (err_pend, err_id registers).

Test Plan:
- Read at 0x1020_0400 (sel=1, TIMER), slave gnt same cycle, r_valid 2 cycles later with rdata 0x1234 and id 3 -> s_req_o = 11'b000_0000_0010; m_r_rdata_o = 0x1234, m_r_id_o = 3; out_cnt returns to 0.
- 4 back-to-back reads to EVENT_U (sel=2), slave withholding r_valid -> 4 grants issued; 5th request sees m_gnt_o = 0 until the first r_valid, then is granted.
- Outstanding read to TIMER, new request to DMA_CL (sel=6) -> s_req_o[6] held 0 until the TIMER response, then granted the same cycle out_cnt reaches 0.
- Access at sel=13, id 7, macro defined -> m_gnt_o = 1; next cycle m_r_valid_o = 1, m_r_opc_o = 1, m_r_id_o = 7, rdata = 0xBADACCE5. Macro undefined -> s_req_o[9] asserted.
- Grant and response in the same cycle at out_cnt = 2 -> out_cnt stays 2.
- rst_ni low with out_cnt = 3 -> all outputs 0 immediately; subsequent spurious s_r_valid_i[1] produces no m_r_valid_o.

Source files
------------

// File: rtl/cluster_periph_demux_pkg.sv
// ----------------------------------------------------------------------------
// pulp_cluster_package
//
// Peripheral index map for the cluster peripheral interconnect, plus the
// constants used by cluster_periph_demux:
//   SPER_*_ID      slave port index of each cluster peripheral
//   NB_SPERIPHS    number of slave peripheral ports
//   PER_SEL_WIDTH  width of the slave-select field in the request address
//   PER_ERR_RDATA  read data pattern returned by the internal error slave
// ----------------------------------------------------------------------------
package pulp_cluster_package;

    localparam int SPER_EOC_ID         = 0;
    localparam int SPER_TIMER_ID       = 1;
    localparam int SPER_EVENT_U_ID     = 2;
    localparam int SPER_LOCKSTEP_ID    = 3;
    localparam int SPER_HWPE_ID        = 4;
    localparam int SPER_ICACHE_CTRL_ID = 5;
    localparam int SPER_DMA_CL_ID      = 6;
    localparam int SPER_DMA_FC_ID      = 7;
    localparam int SPER_DECOMP_ID      = 8;
    localparam int SPER_EXT_ID         = 9;
    localparam int SPER_RFU_ID         = 10;

    localparam int NB_SPERIPHS = 11;

    localparam int          PER_SEL_WIDTH = 4;
    localparam logic [31:0] PER_ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/cluster_periph_demux_err_slv.sv
// ----------------------------------------------------------------------------
// cluster_periph_demux_err_slv
//
// Internal error responder for unmapped peripheral accesses. An accepted
// request (err_req_i) is answered exactly one cycle later with the captured
// ID and the PER_ERR_RDATA pattern. Only built when
// CLUSTER_PERIPH_DEMUX_ERR_RESP_EN is defined.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   err_req_i       handshake to the error target this cycle
//   err_id_i        transaction ID of that handshake
//   r_valid_o       error response valid (also the pending flag)
//   r_id_o          captured transaction ID
//   r_rdata_o       error read data (zero when no response)
// ----------------------------------------------------------------------------
import pulp_cluster_package::*;

module cluster_periph_demux_err_slv #(
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  err_req_i,
    input  logic [ID_WIDTH-1:0]   err_id_i,
    output logic                  r_valid_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o
);

    logic                  err_pend_d, err_pend_q;
    logic [ID_WIDTH-1:0]   err_id_d, err_id_q;
    logic [DATA_WIDTH-1:0] err_pattern;

    // The demux never accepts a new error request while one is pending, so
    // the pending flag simply follows the accepted request by one cycle.
    always_comb begin
        err_pend_d = err_req_i;
        err_id_d   = err_id_q;
        if (err_req_i) begin
            err_id_d = err_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_pend_q <= 1'b0;
            err_id_q   <= '0;
        end else begin
            err_pend_q <= err_pend_d;
            err_id_q   <= err_id_d;
        end
    end

    // Error pattern replicated (or truncated) to the data width.
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_pattern
        assign err_pattern[g] = PER_ERR_RDATA[g % 32];
    end

    assign r_valid_o = err_pend_q;
    assign r_id_o    = err_id_q;
    assign r_rdata_o = err_pattern & {DATA_WIDTH{err_pend_q}};

endmodule

// File: rtl/cluster_periph_demux.sv
// ----------------------------------------------------------------------------
// cluster_periph_demux
//
// Routes requests from the cluster peripheral-interconnect master port to
// NB_SPERIPHS slave peripheral ports, selected by address bits
// [SEL_LSB +: PER_SEL_WIDTH]. All in-flight transactions go to one target;
// a request to a different target waits until the outstanding count drains
// to zero, so responses always return in order.
//
// Configuration macro: CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
//   defined   - unmapped selects hit an internal error slave that answers one
//               cycle later with opc=1 and PER_ERR_RDATA
//   undefined - unmapped selects are redirected to SPER_EXT_ID with the
//               address forwarded unchanged
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   m_req_i .. m_id_i      master request channel
//   m_gnt_o                master grant
//   m_r_*_o                master response channel (valid, opc, id, rdata)
//   s_req_o, s_gnt_i       per-slave request / grant
//   s_add_o .. s_id_o      broadcast request fields, one copy per slave
//   s_r_*_i                per-slave response channel
// ----------------------------------------------------------------------------
import pulp_cluster_package::*;

module cluster_periph_demux #(
    parameter int NB_SPERIPHS     = pulp_cluster_package::NB_SPERIPHS,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 5,
    parameter int SEL_LSB         = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m_req_i,
    input  logic [ADDR_WIDTH-1:0]   m_add_i,
    input  logic                    m_wen_i,
    input  logic [DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m_be_i,
    input  logic [ID_WIDTH-1:0]     m_id_i,
    output logic                    m_gnt_o,
    output logic                    m_r_valid_o,
    output logic                    m_r_opc_o,
    output logic [ID_WIDTH-1:0]     m_r_id_o,
    output logic [DATA_WIDTH-1:0]   m_r_rdata_o,

    output logic [NB_SPERIPHS-1:0]  s_req_o,
    output logic [ADDR_WIDTH-1:0]   s_add_o   [NB_SPERIPHS],
    output logic                    s_wen_o   [NB_SPERIPHS],
    output logic [DATA_WIDTH-1:0]   s_wdata_o [NB_SPERIPHS],
    output logic [DATA_WIDTH/8-1:0] s_be_o    [NB_SPERIPHS],
    output logic [ID_WIDTH-1:0]     s_id_o    [NB_SPERIPHS],
    input  logic [NB_SPERIPHS-1:0]  s_gnt_i,
    input  logic [NB_SPERIPHS-1:0]  s_r_valid_i,
    input  logic [NB_SPERIPHS-1:0]  s_r_opc_i,
    input  logic [ID_WIDTH-1:0]     s_r_id_i    [NB_SPERIPHS],
    input  logic [DATA_WIDTH-1:0]   s_r_rdata_i [NB_SPERIPHS]
);

    // Target index space includes one extra slot for the error slave.
    localparam int TGT_W = $clog2(NB_SPERIPHS + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    localparam logic [TGT_W-1:0] ERR_TGT      = TGT_W'(NB_SPERIPHS);
    localparam logic [TGT_W-1:0] UNMAPPED_TGT = ERR_TGT;
`else
    localparam logic [TGT_W-1:0] UNMAPPED_TGT = TGT_W'(SPER_EXT_ID);
`endif

    logic [PER_SEL_WIDTH-1:0] sel;
    logic                     sel_mapped;
    logic [TGT_W-1:0]         tgt;
    logic                     proceed;
    logic                     handshake;

    logic [CNT_W-1:0] out_cnt_d, out_cnt_q;
    logic [TGT_W-1:0] cur_tgt_d, cur_tgt_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign sel        = m_add_i[SEL_LSB +: PER_SEL_WIDTH];
    assign sel_mapped = (int'(sel) < NB_SPERIPHS);
    assign tgt        = sel_mapped ? TGT_W'(sel) : UNMAPPED_TGT;

    // ------------------------------------------------------------------
    // Optional internal error slave
    // ------------------------------------------------------------------
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
    logic                  err_req;
    logic                  err_r_valid;
    logic [ID_WIDTH-1:0]   err_r_id;
    logic [DATA_WIDTH-1:0] err_r_rdata;

    assign err_req = handshake && (tgt == ERR_TGT);

    cluster_periph_demux_err_slv #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) i_err_slv (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .err_req_i  (err_req),
        .err_id_i   (m_id_i),
        .r_valid_o  (err_r_valid),
        .r_id_o     (err_r_id),
        .r_rdata_o  (err_r_rdata)
    );
`endif

    // ------------------------------------------------------------------
    // Issue rule: room for another transaction, same target as everything
    // in flight, and (for the error slave) no error response pending.
    // Because a full counter blocks issue, a grant can never coincide with
    // the response that frees the slot.
    // ------------------------------------------------------------------
    always_comb begin
        proceed = (out_cnt_q < CNT_MAX) &&
                  ((out_cnt_q == '0) || (tgt == cur_tgt_q));
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
        if ((tgt == ERR_TGT) && err_r_valid) begin
            proceed = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Request path (zero-cycle)
    // ------------------------------------------------------------------
    always_comb begin
        s_req_o = '0;
        m_gnt_o = 1'b0;
        if (m_req_i && proceed) begin
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
            if (tgt == ERR_TGT) begin
                m_gnt_o = 1'b1;
            end else
`endif
            begin
                s_req_o[tgt] = 1'b1;
                m_gnt_o      = s_gnt_i[tgt];
            end
        end
    end

    assign handshake = m_req_i && m_gnt_o;

    for (genvar i = 0; i < NB_SPERIPHS; i++) begin : g_bcast
        assign s_add_o[i]   = m_add_i;
        assign s_wen_o[i]   = m_wen_i;
        assign s_wdata_o[i] = m_wdata_i;
        assign s_be_o[i]    = m_be_i;
        assign s_id_o[i]    = m_id_i;
    end

    // ------------------------------------------------------------------
    // Response path: only the current target is listened to, and only
    // while something is outstanding; everything else is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        m_r_valid_o = 1'b0;
        m_r_opc_o   = 1'b0;
        m_r_id_o    = '0;
        m_r_rdata_o = '0;
        if (out_cnt_q != '0) begin
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
            if (cur_tgt_q == ERR_TGT) begin
                m_r_valid_o = err_r_valid;
                m_r_opc_o   = err_r_valid;
                m_r_id_o    = err_r_id;
                m_r_rdata_o = err_r_rdata;
            end else
`endif
            begin
                m_r_valid_o = s_r_valid_i[cur_tgt_q];
                m_r_opc_o   = s_r_opc_i[cur_tgt_q];
                m_r_id_o    = s_r_id_i[cur_tgt_q];
                m_r_rdata_o = s_r_rdata_i[cur_tgt_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding tracking
    // ------------------------------------------------------------------
    always_comb begin
        out_cnt_d = out_cnt_q;
        cur_tgt_d = cur_tgt_q;
        if (handshake) begin
            cur_tgt_d = tgt;
        end
        case ({handshake, m_r_valid_o})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
            cur_tgt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            cur_tgt_q <= cur_tgt_d;
        end
    end

endmodule

// File: tb/tb_cluster_periph_demux.sv
module tb_cluster_periph_demux;

    localparam int NB = 11;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 5;

    typedef struct packed {
        logic          opc;
        logic [IW-1:0] id;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m_req_i;
    logic [AW-1:0]   m_add_i;
    logic            m_wen_i;
    logic [DW-1:0]   m_wdata_i;
    logic [DW/8-1:0] m_be_i;
    logic [IW-1:0]   m_id_i;
    logic            m_gnt_o;
    logic            m_r_valid_o;
    logic            m_r_opc_o;
    logic [IW-1:0]   m_r_id_o;
    logic [DW-1:0]   m_r_rdata_o;
    logic [NB-1:0]   s_req_o;
    logic [AW-1:0]   s_add_o   [NB];
    logic            s_wen_o   [NB];
    logic [DW-1:0]   s_wdata_o [NB];
    logic [DW/8-1:0] s_be_o    [NB];
    logic [IW-1:0]   s_id_o    [NB];
    logic [NB-1:0]   s_gnt_i;
    logic [NB-1:0]   s_r_valid_i;
    logic [NB-1:0]   s_r_opc_i;
    logic [IW-1:0]   s_r_id_i    [NB];
    logic [DW-1:0]   s_r_rdata_i [NB];

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    cluster_periph_demux dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m_req_i     (m_req_i),
        .m_add_i     (m_add_i),
        .m_wen_i     (m_wen_i),
        .m_wdata_i   (m_wdata_i),
        .m_be_i      (m_be_i),
        .m_id_i      (m_id_i),
        .m_gnt_o     (m_gnt_o),
        .m_r_valid_o (m_r_valid_o),
        .m_r_opc_o   (m_r_opc_o),
        .m_r_id_o    (m_r_id_o),
        .m_r_rdata_o (m_r_rdata_o),
        .s_req_o     (s_req_o),
        .s_add_o     (s_add_o),
        .s_wen_o     (s_wen_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_id_o      (s_id_o),
        .s_gnt_i     (s_gnt_i),
        .s_r_valid_i (s_r_valid_i),
        .s_r_opc_i   (s_r_opc_i),
        .s_r_id_i    (s_r_id_i),
        .s_r_rdata_i (s_r_rdata_i)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every response is popped against the queue.
    always begin
        @(negedge clk);
        #2;
        if (m_r_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d rdata=%h opc=%b, expected no response",
                         m_r_id_o, m_r_rdata_o, m_r_opc_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_r_opc_o, m_r_id_o, m_r_rdata_o} !== mon_e) begin
                    errors++;
                    $display("FAIL rsp_data: got opc=%b id=%0d rdata=%h, expected opc=%b id=%0d rdata=%h",
                             m_r_opc_o, m_r_id_o, m_r_rdata_o, mon_e.opc, mon_e.id, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic clear_req();
        m_req_i   = 1'b0;
        m_add_i   = '0;
        m_wen_i   = 1'b1;
        m_wdata_i = '0;
        m_be_i    = '1;
        m_id_i    = '0;
        s_gnt_i   = '0;
    endtask

    task automatic clear_rsp();
        s_r_valid_i = '0;
        s_r_opc_i   = '0;
        for (int i = 0; i < NB; i++) begin
            s_r_id_i[i]    = '0;
            s_r_rdata_i[i] = '0;
        end
    endtask

    task automatic drive_req(input logic [AW-1:0] addr, input int id, input logic [NB-1:0] gnt);
        m_req_i   = 1'b1;
        m_add_i   = addr;
        m_wen_i   = 1'b1;
        m_wdata_i = 32'hA5A5_0000 + addr;
        m_id_i    = IW'(id);
        s_gnt_i   = gnt;
    endtask

    task automatic drive_rsp(input int slv, input int id, input logic [DW-1:0] rdata);
        clear_rsp();
        s_r_valid_i[slv] = 1'b1;
        s_r_id_i[slv]    = IW'(id);
        s_r_rdata_i[slv] = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_req();
        clear_rsp();
        s_r_valid_i[1] = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({m_gnt_o, m_r_valid_o, m_r_opc_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got gnt/valid/opc=%b, expected 000", {m_gnt_o, m_r_valid_o, m_r_opc_o});
        end
        checks++;
        if (m_r_id_o !== '0 || m_r_rdata_o !== '0 || s_req_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got id=%0d rdata=%h s_req=%b, expected all 0", m_r_id_o, m_r_rdata_o, s_req_o);
        end
        checks++;
        if (dut.out_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d, expected 0", dut.out_cnt_q);
        end
        clear_rsp();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        drive_req(32'h1020_0400, 3, 11'b000_0000_0010);
        #1;
        checks++;
        if (s_req_o !== 11'b000_0000_0010 || m_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL single_req: got s_req=%b gnt=%b, expected 00000000010 1", s_req_o, m_gnt_o);
        end
        checks++;
        if (s_add_o[1] !== 32'h1020_0400 || s_id_o[1] !== 5'd3 || s_wen_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_bcast: got add=%h id=%0d wen=%b, expected 10200400 3 1", s_add_o[1], s_id_o[1], s_wen_o[1]);
        end
        exp_q.push_back('{opc: 1'b0, id: 5'd3, rdata: 32'h0000_1234});
        step();
        clear_req();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd1) begin
            errors++;
            $display("FAIL single_cnt1: got %0d, expected 1", dut.out_cnt_q);
        end
        step();
        drive_rsp(1, 3, 32'h0000_1234);
        #1;
        checks++;
        if (m_r_valid_o !== 1'b1 || m_r_rdata_o !== 32'h1234 || m_r_id_o !== 5'd3) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b rdata=%h id=%0d, expected 1 00001234 3", m_r_valid_o, m_r_rdata_o, m_r_id_o);
        end
        step();
        clear_rsp();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got cnt=%0d pending=%0d, expected 0 0", dut.out_cnt_q, exp_q.size());
        end
    endtask

    task automatic test_outstanding_limit();
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h0000_0800, i, 11'b000_0000_0100);
            #1;
            checks++;
            if (m_gnt_o !== 1'b1) begin
                errors++;
                $display("FAIL limit_gnt%0d: got gnt=%b, expected 1", i, m_gnt_o);
            end
            exp_q.push_back('{opc: 1'b0, id: IW'(i), rdata: 32'hE000_0000 + i});
            step();
        end
        drive_req(32'h0000_0800, 4, 11'b000_0000_0100);
        #1;
        checks++;
        if (m_gnt_o !== 1'b0 || s_req_o !== '0 || dut.out_cnt_q !== 3'd4) begin
            errors++;
            $display("FAIL limit_full: got gnt=%b s_req=%b cnt=%0d, expected 0 0 4", m_gnt_o, s_req_o, dut.out_cnt_q);
        end
        step();
        drive_rsp(2, 0, 32'hE000_0000);
        #1;
        checks++;
        if (m_gnt_o !== 1'b0 || m_r_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL limit_nobypass: got gnt=%b valid=%b, expected 0 1", m_gnt_o, m_r_valid_o);
        end
        step();
        clear_rsp();
        #1;
        checks++;
        if (m_gnt_o !== 1'b1 || s_req_o !== 11'b000_0000_0100) begin
            errors++;
            $display("FAIL limit_5th: got gnt=%b s_req=%b, expected 1 00000000100", m_gnt_o, s_req_o);
        end
        exp_q.push_back('{opc: 1'b0, id: 5'd4, rdata: 32'hE000_0004});
        step();
        clear_req();
        for (int i = 1; i < 5; i++) begin
            drive_rsp(2, i, 32'hE000_0000 + i);
            #1;
            checks++;
            if (m_r_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL limit_drain%0d: got valid=%b, expected 1", i, m_r_valid_o);
            end
            step();
        end
        clear_rsp();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL limit_end: got cnt=%0d pending=%0d, expected 0 0", dut.out_cnt_q, exp_q.size());
        end
    endtask

    task automatic test_target_switch();
        drive_req(32'h1020_0400, 1, 11'b000_0000_0010);
        exp_q.push_back('{opc: 1'b0, id: 5'd1, rdata: 32'h7100_0001});
        step();
        drive_req(32'h0000_1800, 2, 11'b000_0100_0000);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (s_req_o !== '0 || m_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL switch_hold%0d: got s_req=%b gnt=%b, expected 0 0", c, s_req_o, m_gnt_o);
            end
            step();
        end
        drive_rsp(1, 1, 32'h7100_0001);
        #1;
        checks++;
        if (s_req_o !== '0 || m_r_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL switch_rsp: got s_req=%b valid=%b, expected 0 1", s_req_o, m_r_valid_o);
        end
        step();
        clear_rsp();
        #1;
        checks++;
        if (s_req_o !== 11'b000_0100_0000 || m_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL switch_grant: got s_req=%b gnt=%b, expected 00001000000 1", s_req_o, m_gnt_o);
        end
        exp_q.push_back('{opc: 1'b1, id: 5'd2, rdata: 32'hD6A0_0002});
        step();
        clear_req();
        drive_rsp(1, 9, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (m_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL switch_drop: got valid=%b, expected 0", m_r_valid_o);
        end
        step();
        drive_rsp(6, 2, 32'hD6A0_0002);
        s_r_opc_i[6] = 1'b1;
        #1;
        checks++;
        if (m_r_valid_o !== 1'b1 || m_r_opc_o !== 1'b1) begin
            errors++;
            $display("FAIL switch_dma_rsp: got valid=%b opc=%b, expected 1 1", m_r_valid_o, m_r_opc_o);
        end
        step();
        clear_rsp();
    endtask

    task automatic test_unmapped();
`ifdef CLUSTER_PERIPH_DEMUX_ERR_RESP_EN
        drive_req(32'h0000_3400, 7, '1);
        #1;
        checks++;
        if (m_gnt_o !== 1'b1 || s_req_o !== '0) begin
            errors++;
            $display("FAIL err_gnt: got gnt=%b s_req=%b, expected 1 0", m_gnt_o, s_req_o);
        end
        exp_q.push_back('{opc: 1'b1, id: 5'd7, rdata: 32'hBADA_CCE5});
        step();
        drive_req(32'h0000_3400, 8, '1);
        #1;
        checks++;
        if (m_r_valid_o !== 1'b1 || m_r_opc_o !== 1'b1 || m_r_id_o !== 5'd7 || m_r_rdata_o !== 32'hBADA_CCE5) begin
            errors++;
            $display("FAIL err_rsp: got valid=%b opc=%b id=%0d rdata=%h, expected 1 1 7 badacce5",
                     m_r_valid_o, m_r_opc_o, m_r_id_o, m_r_rdata_o);
        end
        checks++;
        if (m_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL err_pend_block: got gnt=%b, expected 0", m_gnt_o);
        end
        step();
        #1;
        checks++;
        if (m_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL err_regrant: got gnt=%b, expected 1", m_gnt_o);
        end
        exp_q.push_back('{opc: 1'b1, id: 5'd8, rdata: 32'hBADA_CCE5});
        step();
        clear_req();
        step();
`else
        drive_req(32'h0000_3400, 7, 11'b010_0000_0000);
        #1;
        checks++;
        if (s_req_o !== 11'b010_0000_0000 || m_gnt_o !== 1'b1 || s_add_o[9] !== 32'h0000_3400) begin
            errors++;
            $display("FAIL ext_redirect: got s_req=%b gnt=%b add=%h, expected 01000000000 1 00003400",
                     s_req_o, m_gnt_o, s_add_o[9]);
        end
        exp_q.push_back('{opc: 1'b0, id: 5'd7, rdata: 32'h0E47_0007});
        step();
        clear_req();
        drive_rsp(9, 7, 32'h0E47_0007);
        #1;
        checks++;
        if (m_r_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ext_rsp: got valid=%b, expected 1", m_r_valid_o);
        end
        step();
        clear_rsp();
`endif
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL unmapped_end: got cnt=%0d pending=%0d, expected 0 0", dut.out_cnt_q, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 10; i < 12; i++) begin
            drive_req(32'h0000_0800, i, 11'b000_0000_0100);
            exp_q.push_back('{opc: 1'b0, id: IW'(i), rdata: 32'h5100_0000 + i});
            step();
        end
        drive_req(32'h0000_0800, 12, 11'b000_0000_0100);
        drive_rsp(2, 10, 32'h5100_000A);
        #1;
        checks++;
        if (m_gnt_o !== 1'b1 || m_r_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_both: got gnt=%b valid=%b, expected 1 1", m_gnt_o, m_r_valid_o);
        end
        exp_q.push_back('{opc: 1'b0, id: 5'd12, rdata: 32'h5100_000C});
        step();
        clear_req();
        clear_rsp();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd2) begin
            errors++;
            $display("FAIL simul_cnt: got %0d, expected 2", dut.out_cnt_q);
        end
        for (int i = 11; i < 13; i++) begin
            drive_rsp(2, i, 32'h5100_0000 + i);
            step();
        end
        clear_rsp();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL simul_end: got cnt=%0d pending=%0d, expected 0 0", dut.out_cnt_q, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 20; i < 23; i++) begin
            drive_req(32'h1020_0400, i, 11'b000_0000_0010);
            exp_q.push_back('{opc: 1'b0, id: IW'(i), rdata: 32'h0});
            step();
        end
        clear_req();
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_cnt3: got %0d, expected 3", dut.out_cnt_q);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        drive_rsp(1, 20, 32'h1111_2222);
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0 || m_r_valid_o !== 1'b0 || m_gnt_o !== 1'b0 || s_req_o !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got cnt=%0d valid=%b gnt=%b s_req=%b, expected 0 0 0 0",
                     dut.out_cnt_q, m_r_valid_o, m_gnt_o, s_req_o);
        end
        checks++;
        if (m_r_id_o !== '0 || m_r_rdata_o !== '0 || m_r_opc_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_data: got id=%0d rdata=%h opc=%b, expected 0 0 0", m_r_id_o, m_r_rdata_o, m_r_opc_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        #1;
        checks++;
        if (m_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_spurious: got valid=%b, expected 0", m_r_valid_o);
        end
        clear_rsp();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_outstanding_limit();
        test_target_switch();
        test_unmapped();
        test_simultaneous();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
